// File: rtl/prbs_gen_check.sv
// prbs_gen_check: parallel PRBS generator (PRBS7/15/23/31) with single-bit
// error injection, plus a self-synchronising checker that locks onto an
// incoming PRBS stream, flags per-bit errors and keeps a saturating count.
module prbs_gen_check #(
  parameter int WIDTH             = 8,
  parameter int ERR_COUNTER_WIDTH = 16,
  parameter int LOCK_THRESHOLD    = 8,
  parameter int UNLOCK_THRESHOLD  = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [1:0]                   mode,
  input  logic                         gen_enable,
  input  logic                         inject_error,
  output logic [WIDTH-1:0]             gen_word,
  output logic                         gen_valid,
  input  logic [WIDTH-1:0]             rx_word,
  input  logic                         rx_valid,
  input  logic                         err_clear,
  output logic                         locked,
  output logic [WIDTH-1:0]             err_word,
  output logic                         err_pulse,
  output logic [ERR_COUNTER_WIDTH-1:0] err_count
);

  // Words needed to fill the 31-bit history before checking is meaningful.
  localparam int PRIME_WORDS = (31 + WIDTH - 1) / WIDTH;
  localparam int PW  = $clog2(PRIME_WORDS + 1);
  localparam int GW  = $clog2(LOCK_THRESHOLD + 1);
  localparam int BW  = $clog2(UNLOCK_THRESHOLD + 1);
  localparam int PCW = $clog2(WIDTH + 1);
  localparam int SW  = ERR_COUNTER_WIDTH + PCW;

  typedef enum logic {SEARCH, LOCKED} state_t;

  logic [1:0]                   mode_reg;
  logic                         mode_change;
  logic [30:0]                  tap_mask;
  logic [30:0]                  win_mask;

  logic [30:0]                  gen_s_reg;
  logic [30:0]                  gen_s_next;
  logic [WIDTH-1:0]             gen_bits;
  logic [WIDTH-1:0]             gen_word_reg;
  logic                         gen_valid_reg;

  logic [30:0]                  hist_reg;
  logic [30:0]                  hist_next;
  logic [WIDTH-1:0]             chk_e;
  logic                         word_bad;
  logic [PCW-1:0]               e_pop;
  logic [PW-1:0]                prime_cnt_reg;
  logic                         priming;

  state_t                       state_reg;
  state_t                       state_next;
  logic [GW-1:0]                good_cnt_reg;
  logic [GW-1:0]                good_cnt_next;
  logic [BW-1:0]                bad_cnt_reg;
  logic [BW-1:0]                bad_cnt_next;

  logic [WIDTH-1:0]             err_word_reg;
  logic                         err_pulse_reg;
  logic [ERR_COUNTER_WIDTH-1:0] err_count_reg;
  logic [ERR_COUNTER_WIDTH-1:0] err_count_next;
  logic [SW-1:0]                sum_wide;

  assign mode_change = (mode != mode_reg);
  assign priming     = (prime_cnt_reg < PW'(PRIME_WORDS));

  assign gen_word  = gen_word_reg;
  assign gen_valid = gen_valid_reg;
  assign locked    = (state_reg == LOCKED);
  assign err_word  = err_word_reg;
  assign err_pulse = err_pulse_reg;
  assign err_count = err_count_reg;

  // Tap pair (n-1, m-1) and the n-bit live window for the registered mode.
  always_comb begin
    tap_mask = 31'h0000_0060;
    win_mask = 31'h0000_007F;
    case (mode_reg)
      2'd0: begin tap_mask = 31'h0000_0060; win_mask = 31'h0000_007F; end
      2'd1: begin tap_mask = 31'h0000_6000; win_mask = 31'h0000_7FFF; end
      2'd2: begin tap_mask = 31'h0042_0000; win_mask = 31'h007F_FFFF; end
      default: begin tap_mask = 31'h4800_0000; win_mask = 31'h7FFF_FFFF; end
    endcase
  end

  // Mode register; any difference from it is treated as a mode change.
  always_ff @(posedge clock) begin
    mode_reg <= mode;
  end

  // Unrolled generator: WIDTH LFSR steps, first new bit lands in the MSB.
  always_comb begin
    gen_s_next = gen_s_reg;
    gen_bits   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      gen_s_next  = {gen_s_next[29:0], ^(gen_s_next & tap_mask)};
      gen_bits[i] = gen_s_next[0];
    end
  end

  // Generator state and output word; injection only touches the output.
  always_ff @(posedge clock) begin
    if (reset) begin
      gen_s_reg     <= '1;
      gen_word_reg  <= '0;
      gen_valid_reg <= 1'b0;
    end else if (mode_change) begin
      gen_s_reg     <= '1;
      gen_valid_reg <= 1'b0;
    end else if (gen_enable) begin
      gen_s_reg     <= gen_s_next;
      gen_word_reg  <= gen_bits ^ WIDTH'(inject_error);
      gen_valid_reg <= 1'b1;
    end else begin
      gen_valid_reg <= 1'b0;
    end
  end

  // Feed-forward check: each rx bit is compared against its own history,
  // including earlier bits of the same word. Zero window counts as bad.
  always_comb begin
    hist_next = hist_reg;
    chk_e     = '0;
    e_pop     = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      chk_e[i]  = rx_word[i] ^ (^(hist_next & tap_mask));
      hist_next = {hist_next[29:0], rx_word[i]};
    end
    for (int i = 0; i < WIDTH; i++) begin
      e_pop = e_pop + PCW'(chk_e[i]);
    end
    word_bad = (|chk_e) || ((hist_next & win_mask) == 31'd0);
  end

  // Lock state machine: next state and run-length counters.
  always_comb begin
    state_next    = state_reg;
    good_cnt_next = good_cnt_reg;
    bad_cnt_next  = bad_cnt_reg;
    if (rx_valid && !priming) begin
      case (state_reg)
        SEARCH: begin
          if (word_bad) begin
            good_cnt_next = '0;
          end else if (good_cnt_reg == GW'(LOCK_THRESHOLD - 1)) begin
            good_cnt_next = good_cnt_reg + 1'b1;
            bad_cnt_next  = '0;
            state_next    = LOCKED;
          end else begin
            good_cnt_next = good_cnt_reg + 1'b1;
          end
        end
        default: begin
          if (!word_bad) begin
            bad_cnt_next = '0;
          end else if (bad_cnt_reg == BW'(UNLOCK_THRESHOLD - 1)) begin
            bad_cnt_next  = '0;
            good_cnt_next = '0;
            state_next    = SEARCH;
          end else begin
            bad_cnt_next = bad_cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

  // Saturating error accumulation while locked; clear beats increment.
  always_comb begin
    sum_wide       = SW'(err_count_reg) + SW'(e_pop);
    err_count_next = err_count_reg;
    if (rx_valid && !priming && !mode_change && state_reg == LOCKED) begin
      if (|sum_wide[SW-1:ERR_COUNTER_WIDTH]) begin
        err_count_next = '1;
      end else begin
        err_count_next = sum_wide[ERR_COUNTER_WIDTH-1:0];
      end
    end
    if (err_clear) begin
      err_count_next = '0;
    end
  end

  // Checker registers: history, priming, lock state and error outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      hist_reg      <= '0;
      prime_cnt_reg <= '0;
      state_reg     <= SEARCH;
      good_cnt_reg  <= '0;
      bad_cnt_reg   <= '0;
      err_word_reg  <= '0;
      err_pulse_reg <= 1'b0;
      err_count_reg <= '0;
    end else begin
      err_count_reg <= err_count_next;
      if (mode_change) begin
        hist_reg      <= '0;
        prime_cnt_reg <= '0;
        state_reg     <= SEARCH;
        good_cnt_reg  <= '0;
        bad_cnt_reg   <= '0;
        err_word_reg  <= '0;
        err_pulse_reg <= 1'b0;
      end else begin
        state_reg    <= state_next;
        good_cnt_reg <= good_cnt_next;
        bad_cnt_reg  <= bad_cnt_next;
        if (rx_valid) begin
          hist_reg <= hist_next;
          if (priming) begin
            prime_cnt_reg <= prime_cnt_reg + 1'b1;
            err_word_reg  <= '0;
            err_pulse_reg <= 1'b0;
          end else begin
            err_word_reg  <= chk_e;
            err_pulse_reg <= (state_reg == LOCKED) && (|chk_e);
          end
        end else begin
          err_word_reg  <= '0;
          err_pulse_reg <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_prbs_gen_check.sv
// tb_prbs_gen_check: directed loopback bench for prbs_gen_check.
module tb_prbs_gen_check;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   mode;
  logic         gen_enable;
  logic         inject_error;
  logic [W-1:0] gen_word;
  logic         gen_valid;
  logic [W-1:0] rx_word;
  logic         rx_valid;
  logic         err_clear;
  logic         locked;
  logic [W-1:0] err_word;
  logic         err_pulse;
  logic [3:0]   err_count;
  logic         zero_rx;

  int checks = 0;
  int errors = 0;

  int           words;
  int           gwords;
  int           lock_word;
  int           pulses;
  logic         timeout;
  logic [W-1:0] hist [0:255];

  prbs_gen_check #(
    .WIDTH(W), .ERR_COUNTER_WIDTH(4), .LOCK_THRESHOLD(8), .UNLOCK_THRESHOLD(4)
  ) dut (
    .clock(clock), .reset(reset), .mode(mode), .gen_enable(gen_enable),
    .inject_error(inject_error), .gen_word(gen_word), .gen_valid(gen_valid),
    .rx_word(rx_word), .rx_valid(rx_valid), .err_clear(err_clear),
    .locked(locked), .err_word(err_word), .err_pulse(err_pulse),
    .err_count(err_count)
  );

  always #5 clock = ~clock;

  assign rx_word  = zero_rx ? '0 : gen_word;
  assign rx_valid = zero_rx ? 1'b1 : gen_valid;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Run loopback until n rx words are consumed, recording generated words,
  // the word index at which locked first appears, and err_pulse activity.
  task automatic run_words(input int n);
    int budget;
    budget    = 2 * n + 100;
    words     = 0;
    gwords    = 0;
    lock_word = -1;
    pulses    = 0;
    timeout   = 1'b0;
    while (words < n && budget > 0) begin
      if (rx_valid) words++;
      step();
      budget--;
      if (gen_valid) begin
        if (gwords < 256) hist[gwords] = gen_word;
        gwords++;
      end
      if (locked && lock_word < 0) lock_word = words;
      if (err_pulse) pulses++;
    end
    if (words < n) timeout = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mism;
    int relock;
    int exp_i;
    logic [W-1:0] exp_w;

    reset = 1'b1; mode = 2'd0; gen_enable = 1'b0; inject_error = 1'b0;
    err_clear = 1'b0; zero_rx = 1'b0;
    repeat (3) step();
    chk("rst_gen_word", gen_word, 0);
    chk("rst_gen_valid", gen_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err_word", err_word, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_count", err_count, 0);

    // Generator latency, hand-computed PRBS7 words, and hold on pause.
    reset = 1'b0; gen_enable = 1'b1;
    step(); chk("gen_valid_w1", gen_valid, 1); chk("gen_w1", gen_word, 8'h02);
    step(); chk("gen_w2", gen_word, 8'h0C);
    gen_enable = 1'b0;
    step(); chk("pause_valid", gen_valid, 0); chk("pause_hold", gen_word, 8'h0C);
    step(); chk("pause_hold2", gen_word, 8'h0C); chk("pause_err_word", err_word, 0);
    gen_enable = 1'b1;
    step(); chk("gen_w3", gen_word, 8'h28);
    step(); chk("gen_w4", gen_word, 8'hF2);

    // Mode 0 loopback from reset.
    reset = 1'b1; step(); reset = 1'b0;
    run_words(2000);
    chk("m0_timeout", timeout, 0);
    chk("m0_lock_word", lock_word, 12);
    chk("m0_hist0", hist[0], 8'h02);
    chk("m0_hist3", hist[3], 8'hF2);
    mism = 0;
    for (int i = 0; i < 127; i++) if (hist[i] !== hist[i+127]) mism++;
    chk("m0_period127", mism, 0);
    chk("m0_pulses", pulses, 0);
    chk("m0_err_count", err_count, 0);
    chk("m0_locked", locked, 1);

    // Single injected error while locked: own bit, then taps at distance 6/7.
    inject_error = 1'b1; step(); inject_error = 1'b0;
    step();
    chk("inj_err_word1", err_word, 8'h01);
    chk("inj_pulse1", err_pulse, 1);
    chk("inj_count1", err_count, 1);
    step();
    chk("inj_err_word2", err_word, 8'h06);
    chk("inj_count2", err_count, 3);
    step();
    chk("inj_err_word3", err_word, 0);
    chk("inj_pulse3", err_pulse, 0);
    chk("inj_locked", locked, 1);

    // Saturation of the 4-bit counter, then clear.
    repeat (6) begin
      inject_error = 1'b1; step(); inject_error = 1'b0;
      repeat (19) step();
    end
    chk("sat_count", err_count, 4'hF);
    chk("sat_locked", locked, 1);
    err_clear = 1'b1; step(); err_clear = 1'b0;
    chk("clear_count", err_count, 0);

    // Clear coinciding with an increment wins; the following increment lands.
    inject_error = 1'b1; step(); inject_error = 1'b0;
    err_clear = 1'b1; step(); err_clear = 1'b0;
    chk("clear_wins", err_count, 0);
    step(); chk("after_clear_inc", err_count, 2);
    repeat (5) step();

    // Mode change 0 -> 3 mid-stream.
    mode = 2'd3;
    step();
    chk("mc_locked", locked, 0);
    chk("mc_count_held", err_count, 2);
    chk("mc_gen_valid", gen_valid, 0);
    run_words(5000);
    chk("mc_timeout", timeout, 0);
    chk("mc_lock_word", lock_word, 12);
    chk("mc_hist0", hist[0], 8'h00);
    chk("mc_hist3", hist[3], 8'h0E);
    chk("mc_pulses", pulses, 0);
    chk("mc_count_final", err_count, 2);

    // Reset mid-lock with gen_enable held high.
    reset = 1'b1; step();
    chk("rml_gen_word", gen_word, 0);
    chk("rml_gen_valid", gen_valid, 0);
    chk("rml_locked", locked, 0);
    chk("rml_err_word", err_word, 0);
    chk("rml_err_pulse", err_pulse, 0);
    chk("rml_err_count", err_count, 0);
    reset = 1'b0;

    // Modes 1..3 from reset.
    for (int md = 1; md <= 3; md++) begin
      case (md)
        1:       begin exp_i = 1; exp_w = 8'h02; end
        2:       begin exp_i = 2; exp_w = 8'h3E; end
        default: begin exp_i = 3; exp_w = 8'h0E; end
      endcase
      reset = 1'b1; mode = 2'(md); step(); reset = 1'b0;
      run_words(5000);
      chk($sformatf("m%0d_timeout", md), timeout, 0);
      chk($sformatf("m%0d_lock_word", md), lock_word, 12);
      chk($sformatf("m%0d_word%0d", md, exp_i), hist[exp_i], exp_w);
      chk($sformatf("m%0d_err_count", md), err_count, 0);
      chk($sformatf("m%0d_pulses", md), pulses, 0);
    end

    // All-zero input after lock: zero guard drops lock after 4 words.
    reset = 1'b1; mode = 2'd0; step(); reset = 1'b0;
    run_words(30);
    chk("z_locked_before", locked, 1);
    zero_rx = 1'b1;
    repeat (3) step();
    chk("z_locked_3", locked, 1);
    step();
    chk("z_locked_4", locked, 0);
    relock = 0;
    repeat (50) begin
      step();
      if (locked) relock++;
    end
    chk("z_no_relock", relock, 0);
    zero_rx = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
